// File: rtl/rcv_pkg.sv
// Shared types and frame-type constants for the receive frame controller.
package rcv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StDrop,
    StCheck,
    StDrain
  } state_e;

  localparam logic [7:0] TypeRaw     = 8'h30;
  localparam logic [7:0] TypeData    = 8'h31;
  localparam logic [7:0] TypeDataAck = 8'h32;
  localparam logic [7:0] TypeAck     = 8'h33;

  function automatic logic has_fcs(input logic [7:0] frame_type);
    return (frame_type == TypeData) || (frame_type == TypeDataAck) || (frame_type == TypeAck);
  endfunction

endpackage

// File: rtl/rcv_frame_ctrl_if.sv
// Receive-side, payload-stream and ACK signals of the frame controller.
interface rcv_frame_ctrl_if #(
  parameter int unsigned ERR_W = 8
);
  logic [7:0]       mac;
  logic             cardet;
  logic             valid;
  logic [7:0]       data_rcvr;
  logic             crc_ok;
  logic             crc_en;
  logic             crc_clr;
  logic [7:0]       rdata;
  logic             rvalid;
  logic             rrdy;
  logic             ack_req;
  logic             ack_rcvd;
  logic [7:0]       ack_addr;
  logic [ERR_W-1:0] rerrcount;
  logic             busy;

  modport master (
    input  mac, cardet, valid, data_rcvr, crc_ok, rrdy,
    output crc_en, crc_clr, rdata, rvalid, ack_req, ack_rcvd, ack_addr, rerrcount, busy
  );

  modport slave (
    output mac, cardet, valid, data_rcvr, crc_ok, rrdy,
    input  crc_en, crc_clr, rdata, rvalid, ack_req, ack_rcvd, ack_addr, rerrcount, busy
  );
endinterface

// File: rtl/rcv_frame_buf.sv
// Simple dual-port frame buffer: synchronous write, registered read that holds when re_i is low.
module rcv_frame_buf #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem [2**ADDR_W];
  logic [7:0] rdata_d, rdata_q;

  // Holding the read register keeps the drained byte stable during a stall.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem[raddr_i];
  end

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rcv_frame_ctrl.sv
// Receive frame controller: address filter, buffering, frame-type/FCS check, payload drain, ACKs.
module rcv_frame_ctrl
  import rcv_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned ERR_W  = 8,
  parameter logic [7:0]  BCAST  = 8'h2A,
  parameter bit          FCS_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  rcv_frame_ctrl_if.master  bus
);

  typedef logic [ADDR_W-1:0] ptr_t;
  localparam ptr_t PtrOne   = ptr_t'(1);
  localparam ptr_t PtrTwo   = ptr_t'(2);
  localparam ptr_t PtrThree = ptr_t'(3);
  localparam ptr_t PtrFour  = ptr_t'(4);
  localparam ptr_t PtrLast  = '1;

  state_e           state_d, state_q;
  ptr_t             wr_ptr_d, wr_ptr_q;
  ptr_t             rd_ptr_d, rd_ptr_q;
  ptr_t             end_d, end_q;
  logic [7:0]       dest_d, dest_q;
  logic [7:0]       src_d, src_q;
  logic [7:0]       type_d, type_q;
  logic [7:0]       ack_addr_d, ack_addr_q;
  logic             rvalid_d, rvalid_q;
  logic             ack_req_d, ack_req_q;
  logic             ack_rcvd_d, ack_rcvd_q;
  logic [ERR_W-1:0] rerr_d, rerr_q;
  logic             armed_d, armed_q;
  logic             cardet_q;

  logic       store, we, re, err_inc, fcs, crc_good;
  ptr_t       waddr, raddr, payload_end;
  logic [7:0] rd_data;

  rcv_frame_buf #(
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.data_rcvr),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    end_d      = end_q;
    dest_d     = dest_q;
    src_d      = src_q;
    type_d     = type_q;
    ack_addr_d = ack_addr_q;
    rvalid_d   = rvalid_q;
    ack_req_d  = 1'b0;
    ack_rcvd_d = 1'b0;
    armed_d    = armed_q;
    store      = 1'b0;
    re         = 1'b0;
    err_inc    = 1'b0;
    waddr      = wr_ptr_q;
    raddr      = rd_ptr_q;
    fcs         = has_fcs(type_q);
    crc_good    = !FCS_EN || bus.crc_ok;
    payload_end = wr_ptr_q - (fcs ? PtrOne : '0);

    unique case (state_q)
      StIdle: begin
        wr_ptr_d = '0;
        // A frame already in flight when we came back to IDLE stays ignored until cardet drops.
        armed_d  = armed_q | ~bus.cardet;
        if (bus.valid && bus.cardet && (armed_q || !cardet_q)) begin
          armed_d = 1'b0;
          if (bus.data_rcvr == bus.mac || bus.data_rcvr == BCAST) begin
            store    = 1'b1;
            waddr    = '0;
            wr_ptr_d = PtrOne;
            dest_d   = bus.data_rcvr;
            state_d  = StRecv;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StRecv: begin
        if (bus.valid && wr_ptr_q == PtrLast) begin
          err_inc = 1'b1;
          state_d = StDrop;
        end else begin
          if (bus.valid) begin
            store    = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrOne;
            if (wr_ptr_q == PtrOne) src_d = bus.data_rcvr;
            if (wr_ptr_q == PtrTwo) type_d = bus.data_rcvr;
          end
          if (!bus.cardet) state_d = StCheck;
        end
      end
      StDrop: begin
        if (!bus.cardet) state_d = StIdle;
      end
      StCheck: begin
        state_d = StIdle;
        end_d   = payload_end;
        if (wr_ptr_q < PtrThree || (fcs && wr_ptr_q < PtrFour)) begin
          err_inc = 1'b1;
        end else begin
          case (type_q)
            TypeRaw, TypeData, TypeDataAck: begin
              if (type_q == TypeRaw || crc_good) begin
                if (type_q == TypeDataAck && dest_q == bus.mac) begin
                  ack_req_d  = 1'b1;
                  ack_addr_d = src_q;
                end
                // Prefetch the first payload byte so rvalid rises on the first DRAIN cycle.
                if (payload_end > PtrThree) begin
                  re       = 1'b1;
                  raddr    = PtrThree;
                  rd_ptr_d = PtrFour;
                  rvalid_d = 1'b1;
                  state_d  = StDrain;
                end
              end else begin
                err_inc = 1'b1;
              end
            end
            TypeAck: begin
              if (crc_good && dest_q == bus.mac) begin
                ack_rcvd_d = 1'b1;
                ack_addr_d = src_q;
              end else begin
                err_inc = 1'b1;
              end
            end
            default: err_inc = 1'b1;
          endcase
        end
      end
      StDrain: begin
        if (rvalid_q && bus.rrdy) begin
          if (rd_ptr_q == end_q) begin
            rvalid_d = 1'b0;
            state_d  = StIdle;
          end else begin
            re       = 1'b1;
            rd_ptr_d = rd_ptr_q + PtrOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    rerr_d = (err_inc && rerr_q != '1) ? rerr_q + ERR_W'(1) : rerr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      end_q      <= '0;
      dest_q     <= '0;
      src_q      <= '0;
      type_q     <= '0;
      ack_addr_q <= '0;
      rvalid_q   <= 1'b0;
      ack_req_q  <= 1'b0;
      ack_rcvd_q <= 1'b0;
      rerr_q     <= '0;
      armed_q    <= 1'b1;
      cardet_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      end_q      <= end_d;
      dest_q     <= dest_d;
      src_q      <= src_d;
      type_q     <= type_d;
      ack_addr_q <= ack_addr_d;
      rvalid_q   <= rvalid_d;
      ack_req_q  <= ack_req_d;
      ack_rcvd_q <= ack_rcvd_d;
      rerr_q     <= rerr_d;
      armed_q    <= armed_d;
      cardet_q   <= bus.cardet;
    end
  end

  assign we            = store & ~rst;
  assign bus.crc_en    = we;
  assign bus.crc_clr   = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.rdata     = rd_data;
  assign bus.rvalid    = rvalid_q;
  assign bus.ack_req   = ack_req_q;
  assign bus.ack_rcvd  = ack_rcvd_q;
  assign bus.ack_addr  = ack_addr_q;
  assign bus.rerrcount = rerr_q;

endmodule

// File: tb/tb_rcv_frame_ctrl.sv
// Directed bench for rcv_frame_ctrl with ADDR_W=4, ERR_W=4, mac=05.
module tb_rcv_frame_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned EW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rcv_frame_ctrl_if #(.ERR_W(EW)) bus ();

  rcv_frame_ctrl #(
    .ADDR_W (AW),
    .ERR_W  (EW),
    .BCAST  (8'h2A),
    .FCS_EN (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  int         ack_req_cnt  = 0;
  int         ack_rcvd_cnt = 0;
  logic [7:0] last_ack     = 8'h00;
  int         stall_err    = 0;
  logic       prev_stall   = 1'b0;
  logic [7:0] prev_data    = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.rvalid && bus.rrdy) rx_q.push_back(bus.rdata);
      if (bus.ack_req) begin ack_req_cnt++; last_ack = bus.ack_addr; end
      if (bus.ack_rcvd) begin ack_rcvd_cnt++; last_ack = bus.ack_addr; end
      if (prev_stall && (!bus.rvalid || bus.rdata !== prev_data)) stall_err++;
      prev_stall = bus.rvalid && !bus.rrdy;
      prev_data  = bus.rdata;
    end
  end

  logic [7:0] frame_q[$];
  logic [7:0] exp_q[$];
  int         exp_err;
  int         rx_base, req_base, rcvd_base;
  logic       toggle_rrdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each byte is a one-cycle valid strobe followed by a gap cycle.
  task automatic send_frame(input bit coincide);
    bus.cardet = 1'b1;
    tick();
    for (int i = 0; i < frame_q.size(); i++) begin
      bus.valid     = 1'b1;
      bus.data_rcvr = frame_q[i];
      if (coincide && i == frame_q.size() - 1) bus.cardet = 1'b0;
      tick();
      bus.valid = 1'b0;
      tick();
    end
    bus.cardet = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while (bus.busy && n < 300) begin
      if (toggle_rrdy) bus.rrdy = ~bus.rrdy;
      tick();
      n++;
    end
    chk("idle_timeout", bus.busy, 1'b0);
    tick();
    tick();
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!bus.rvalid && n < 300) begin
      tick();
      n++;
    end
    chk("rvalid_timeout", bus.rvalid, 1'b1);
  endtask

  task automatic mark();
    rx_base   = rx_q.size();
    req_base  = ack_req_cnt;
    rcvd_base = ack_rcvd_cnt;
  endtask

  task automatic check_frame(input string tag, input int reqs, input int rcvds);
    chk({tag, "_rx_count"}, rx_q.size() - rx_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rx_base + i < rx_q.size()) chk({tag, "_rx_byte"}, rx_q[rx_base + i], exp_q[i]);
    end
    chk({tag, "_ack_req"}, ack_req_cnt - req_base, reqs);
    chk({tag, "_ack_rcvd"}, ack_rcvd_cnt - rcvd_base, rcvds);
    chk({tag, "_rerrcount"}, bus.rerrcount, exp_err);
  endtask

  initial begin
    rst           = 1'b1;
    bus.mac       = 8'h05;
    bus.cardet    = 1'b0;
    bus.valid     = 1'b0;
    bus.data_rcvr = 8'h00;
    bus.crc_ok    = 1'b0;
    bus.rrdy      = 1'b1;
    exp_err       = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_rvalid", bus.rvalid, 1'b0);
    chk("reset_crc_clr", bus.crc_clr, 1'b1);
    chk("reset_crc_en", bus.crc_en, 1'b0);
    chk("reset_ack", {bus.ack_req, bus.ack_rcvd, bus.ack_addr}, 10'h000);
    chk("reset_rerrcount", bus.rerrcount, 0);

    // Plain type-0 frame.
    mark(); frame_q = '{8'h05, 8'h07, 8'h30, 8'h41, 8'h42}; exp_q = '{8'h41, 8'h42};
    send_frame(1'b0); wait_idle(); check_frame("type0", 0, 0);

    // ACK-requesting frame, good FCS.
    bus.crc_ok = 1'b1;
    mark(); frame_q = '{8'h05, 8'h07, 8'h32, 8'h55, 8'hC3}; exp_q = '{8'h55};
    send_frame(1'b0); wait_idle(); check_frame("type2_good", 1, 0);
    chk("type2_ack_addr", last_ack, 8'h07);

    // Same frame, bad FCS.
    bus.crc_ok = 1'b0; exp_err = 1;
    mark(); exp_q = {};
    send_frame(1'b0); wait_idle(); check_frame("type2_bad", 0, 0);

    // Broadcast copy of a type-2 frame: payload but no ACK.
    bus.crc_ok = 1'b1;
    mark(); frame_q = '{8'h2A, 8'h07, 8'h32, 8'h66, 8'h11}; exp_q = '{8'h66};
    send_frame(1'b0); wait_idle(); check_frame("bcast", 0, 0);

    // Foreign frame dropped silently, next frame received normally.
    mark(); frame_q = '{8'h09, 8'h07, 8'h30, 8'h77}; exp_q = {};
    send_frame(1'b0); wait_idle(); check_frame("foreign", 0, 0);
    mark(); frame_q = '{8'h05, 8'h07, 8'h30, 8'h88}; exp_q = '{8'h88};
    send_frame(1'b0); wait_idle(); check_frame("after_drop", 0, 0);

    // Received ACK frame.
    mark(); frame_q = '{8'h05, 8'h0B, 8'h33, 8'hEE}; exp_q = {};
    send_frame(1'b0); wait_idle(); check_frame("ack_frame", 0, 1);
    chk("ack_rcvd_addr", last_ack, 8'h0B);

    // Too short, and unknown type.
    exp_err = 2;
    mark(); frame_q = '{8'h05, 8'h07}; exp_q = {};
    send_frame(1'b0); wait_idle(); check_frame("short", 0, 0);
    exp_err = 3;
    mark(); frame_q = '{8'h05, 8'h07, 8'h34, 8'h11};
    send_frame(1'b0); wait_idle(); check_frame("bad_type", 0, 0);

    // Overflow: 20 bytes into a 16-byte buffer.
    exp_err = 4;
    mark(); frame_q = '{8'h05, 8'h07, 8'h30};
    for (int i = 0; i < 17; i++) frame_q.push_back(8'(8'h60 + i));
    send_frame(1'b0); wait_idle(); check_frame("overflow", 0, 0);

    // Last byte strobed in the same cycle cardet falls.
    mark(); frame_q = '{8'h05, 8'h07, 8'h30, 8'hA1, 8'hA2}; exp_q = '{8'hA1, 8'hA2};
    send_frame(1'b1); wait_idle(); check_frame("coincide", 0, 0);

    // Toggling rrdy during drain.
    toggle_rrdy = 1'b1; bus.rrdy = 1'b0;
    mark(); frame_q = '{8'h05, 8'h07, 8'h30, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    send_frame(1'b0); wait_idle(); check_frame("rrdy_toggle", 0, 0);
    toggle_rrdy = 1'b0; bus.rrdy = 1'b1;
    chk("stall_stability", stall_err, 0);

    // A frame arriving during a stalled drain is ignored.
    bus.rrdy = 1'b0;
    mark(); frame_q = '{8'h05, 8'h07, 8'h30, 8'hD1, 8'hD2}; exp_q = '{8'hD1, 8'hD2};
    send_frame(1'b0); wait_rvalid();
    frame_q = '{8'h05, 8'h07, 8'h30, 8'h99};
    send_frame(1'b0);
    bus.rrdy = 1'b1;
    wait_idle(); check_frame("ignore_in_drain", 0, 0);

    // Reset in the middle of a stalled drain.
    bus.rrdy = 1'b0;
    mark(); frame_q = '{8'h05, 8'h07, 8'h30, 8'hC1, 8'hC2, 8'hC3}; exp_q = {};
    send_frame(1'b0); wait_rvalid();
    rst = 1'b1; tick(); rst = 1'b0; bus.rrdy = 1'b1;
    chk("rst_drain_rvalid", bus.rvalid, 1'b0);
    chk("rst_drain_busy", bus.busy, 1'b0);
    chk("rst_drain_crc_clr", bus.crc_clr, 1'b1);
    chk("rst_drain_ack_addr", bus.ack_addr, 8'h00);
    exp_err = 0;
    repeat (3) tick();
    check_frame("rst_drain", 0, 0);
    mark(); frame_q = '{8'h05, 8'h07, 8'h30, 8'hE1}; exp_q = '{8'hE1};
    send_frame(1'b0); wait_idle(); check_frame("after_rst", 0, 0);

    // Error counter saturates at 15.
    mark(); frame_q = '{8'h05}; exp_q = {};
    for (int i = 0; i < 17; i++) begin
      send_frame(1'b0);
      wait_idle();
    end
    exp_err = 15;
    check_frame("saturate", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
